spi_instr_tx: RTL and testbench

Host-side SPI instruction transmitter, the sending end of the CPU's serial instruction interface. It accepts 4-bit opcode / 4-bit operand pairs over a valid/ready handshake, buffers them, and shifts each pair out as one 8-bit SPI mode-0 frame (opcode MSB first, then operand). It is the frame source that the CPU's SPI receiver and instruction decoder consume, used as a companion master on the test chip and as the bench driver.

---
 rtl/spi_cpu_pkg.sv | 9 +
 rtl/instr_fifo.sv | 43 ++++
 rtl/spi_instr_tx.sv | 130 +++++++++++++
 tb/tb_spi_instr_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/spi_cpu_pkg.sv
// spi_cpu_pkg: widths, opcode constants and FSM encoding shared by the SPI instruction link.
package spi_cpu_pkg;
  localparam int FRAME_W  = 8;
  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] OP_LDA = 4'h0;
  localparam logic [NIBBLE_W-1:0] OP_ADD = 4'hA;
  localparam logic [NIBBLE_W-1:0] OP_INV = 4'hF;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_e;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: power-of-two circular FIFO with wrap-around pointers and an occupancy count.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign dout  = mem_q[rd_q];
  assign full  = cnt_q == (AW + 1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/spi_instr_tx.sv
// spi_instr_tx: SPI mode-0 master sending {opcode, operand} frames MSB first.
// SPI_INSTR_TX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of a single holding register.
module spi_instr_tx
  import spi_cpu_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [NIBBLE_W-1:0] instr_opcode,
  input  logic [NIBBLE_W-1:0] instr_operand,
  output logic                spi_sclk,
  output logic                spi_mosi,
  output logic                spi_cs_n,
  output logic                busy
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] H_M1 = CW'(CLK_DIV - 1);
  if (CLK_DIV < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("spi_instr_tx: CLK_DIV must be >= 1 and FIFO_DEPTH a power of two >= 2");
  end
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]   sh_q, sh_d, din, head;
  logic                 sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d;
  logic                 push, pop, full, empty, occupied, done;
  assign din         = {instr_opcode, instr_operand};
  assign instr_ready = !full;
  assign push        = instr_valid && !full;
  assign pop         = state_q == IDLE && !empty;
`ifdef SPI_INSTR_TX_FIFO_EN
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  instr_fifo #(.DEPTH(FIFO_DEPTH), .W(FRAME_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
    .dout(head), .full(full), .empty(empty), .count(fifo_count)
  );
  assign occupied = fifo_count != '0;
`else
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic               full_q, full_d;
  always_comb begin
    hold_d = push ? din : hold_q;
    full_d = push ? 1'b1 : pop ? 1'b0 : full_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end
  assign head     = hold_q;
  assign full     = full_q;
  assign empty    = !full_q;
  assign occupied = full_q;
`endif
  assign done = cnt_q == '0;
  always_comb begin
    state_d   = state_q;
    cnt_d     = done ? H_M1 : cnt_q - 1'b1;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    case (state_q)
      IDLE: begin
        cnt_d = H_M1;
        if (!empty) begin
          state_d   = SETUP;
          sh_d      = head;
          mosi_d    = head[FRAME_W-1];
          cs_d      = 1'b0;
          bit_cnt_d = 3'd7;
        end
      end
      SETUP: if (done) begin
        state_d = SHIFT_HI;
        sclk_d  = 1'b1;
      end
      SHIFT_HI: if (done) begin
        state_d   = SHIFT_LO;
        sclk_d    = 1'b0;
        bit_cnt_d = bit_cnt_q - 1'b1;
        if (bit_cnt_q != 3'd0) begin
          sh_d   = sh_q << 1;
          mosi_d = sh_q[FRAME_W-2];
        end
      end
      // bit counter wraps to 7 only after the bit-0 high phase
      SHIFT_LO: if (done) begin
        state_d = bit_cnt_q == 3'd7 ? GAP : SHIFT_HI;
        sclk_d  = bit_cnt_q != 3'd7;
        cs_d    = bit_cnt_q == 3'd7;
        mosi_d  = bit_cnt_q == 3'd7 ? 1'b0 : mosi_q;
      end
      GAP: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
    end
  end
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_q;
  assign busy     = state_q != IDLE || occupied;
endmodule

// File: tb/tb_spi_instr_tx.sv
// tb_spi_instr_tx: scoreboard bench for spi_instr_tx at CLK_DIV=2 (instance 0) and CLK_DIV=1 (instance 1).
module tb_spi_instr_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] valid, ready, sclk, mosi, cs_n, busy;
  logic [3:0] op [2];
  logic [3:0] opr [2];
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  spi_instr_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(valid[0]), .instr_ready(ready[0]),
    .instr_opcode(op[0]), .instr_operand(opr[0]), .spi_sclk(sclk[0]),
    .spi_mosi(mosi[0]), .spi_cs_n(cs_n[0]), .busy(busy[0])
  );
  spi_instr_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(valid[1]), .instr_ready(ready[1]),
    .instr_opcode(op[1]), .instr_operand(opr[1]), .spi_sclk(sclk[1]),
    .spi_mosi(mosi[1]), .spi_cs_n(cs_n[1]), .busy(busy[1])
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int H = (g == 0) ? 2 : 1;
    logic [7:0] q[$];
    initial forever begin
      @(posedge clk);
      if (rst_n && valid[g] && ready[g]) q.push_back({op[g], opr[g]});
    end
    initial begin
      logic [7:0] sh, exp;
      int nb, low, cyc, last_fall;
      logic pcs, psclk, infr;
      pcs = 1'b1; psclk = 1'b0; infr = 1'b0; cyc = 0; last_fall = -1000;
      sh = '0; nb = 0; low = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
          q.delete();
          infr = 1'b0; pcs = 1'b1; psclk = 1'b0; last_fall = -1000;
        end else begin
          if (pcs && !cs_n[g]) begin
            infr = 1'b1; nb = 0; low = 0; sh = '0;
            if (cyc - last_fall < 60) check($sformatf("period%0d", g), cyc - last_fall, 18 * H + 1);
            last_fall = cyc;
          end
          if (!cs_n[g]) low++;
          if (infr && sclk[g] && !psclk) begin
            sh = {sh[6:0], mosi[g]};
            nb++;
          end
          if (infr && !pcs && cs_n[g]) begin
            infr = 1'b0;
            if (q.size() == 0) begin
              total++;
              $display("FAIL frame%0d: got unexpected frame 0x%02h, expected none", g, sh);
            end else begin
              exp = q.pop_front();
              check($sformatf("frame%0d_data", g), int'(sh), int'(exp));
            end
            check($sformatf("frame%0d_cs_low", g), low, 17 * H);
            check($sformatf("frame%0d_sclk_rises", g), nb, 8);
          end
          pcs = cs_n[g];
          psclk = sclk[g];
        end
      end
    end
  end

  task automatic send(input int g, input logic [3:0] o, input logic [3:0] d, output int waited);
    valid[g] = 1'b1; op[g] = o; opr[g] = d; waited = 0;
    while (!ready[g] && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited == 400) fail("send");
    @(negedge clk);
  endtask

  task automatic wait_cs(input int g, input logic lvl);
    int n = 0;
    while (cs_n[g] !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) fail("wait_cs");
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (busy[g] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n == 1000) fail("wait_idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w[6];
    int lowcnt;
    valid = '0;
    op[0] = '0; op[1] = '0; opr[0] = '0; opr[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n[0], 1);
    check("rst_sclk", sclk[0], 0);
    check("rst_mosi", mosi[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_ready", ready[0], 1);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD 5 -> 0xA5, then busy must stay up through GAP
    send(0, 4'hA, 4'h5, w[0]);
    valid[0] = 1'b0;
    wait_cs(0, 1'b0);
    wait_cs(0, 1'b1);
    check("gap_busy", busy[0], 1);
    repeat (2) @(negedge clk);
    check("idle_busy", busy[0], 0);
    repeat (40) @(negedge clk);

`ifdef SPI_INSTR_TX_FIFO_EN
    for (int i = 0; i < 6; i++) send(0, 4'(i), 4'(i), w[i]);
    valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) check($sformatf("burst_wait%0d", i), w[i], 0);
    check("stall_wait", w[5], 34);
    wait_idle(0);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 6; i++) send(0, 4'(15 - i), 4'(i + 8), w[i]);
    valid[0] = 1'b0;
    check("wrap_stall_wait", w[5], 34);
`else
    send(0, 4'h1, 4'h2, w[0]);
    send(0, 4'h3, 4'h4, w[1]);
    send(0, 4'h5, 4'h6, w[2]);
    valid[0] = 1'b0;
    check("hold_wait0", w[0], 0);
    check("hold_wait1", w[1], 1);
    check("hold_wait2", w[2], 36);
`endif
    wait_idle(0);
    repeat (40) @(negedge clk);

    // abort frame 0xF0 while bit 3 is high
    send(0, 4'hF, 4'h0, w[0]);
    valid[0] = 1'b0;
    wait_cs(0, 1'b0);
    repeat (18) @(negedge clk);
    check("pre_rst_sclk", sclk[0], 1);
    check("pre_rst_cs_n", cs_n[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n", cs_n[0], 1);
    check("abort_sclk", sclk[0], 0);
    check("abort_mosi", mosi[0], 0);
    check("abort_ready", ready[0], 1);
    check("abort_busy", busy[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lowcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!cs_n[0]) lowcnt++;
    end
    check("no_frame_after_abort", lowcnt, 0);
    check("abort_busy_after", busy[0], 0);

    // CLK_DIV=1: 0x7C
    send(1, 4'h7, 4'hC, w[0]);
    valid[1] = 1'b0;
    wait_cs(1, 1'b0);
    wait_cs(1, 1'b1);
    repeat (10) @(negedge clk);

    check("q0_drained", mon[0].q.size(), 0);
    check("q1_drained", mon[1].q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
